// File: rtl/mdio_pkg.sv
// mdio_pkg: shared frame constants and FSM state encoding for the MDIO controller.
package mdio_pkg;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam int         HDR_LEN  = 16;
    localparam int         TA_LEN   = 2;
    localparam int         DATA_LEN = 16;
    typedef enum logic [2:0] {IDLE, SEND, TA, RECV, DONE} state_e;
endpackage

// File: rtl/mdio_shift_reg.sv
// mdio_shift_reg: parallel-load shift register, serial out at MSB, serial in at LSB.
module mdio_shift_reg #(
    parameter int W = 32,
    parameter int P = 15
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    input  logic         ser_i,
    output logic         ser_o,
    output logic [P-1:0] par_o
);
    logic [W-1:0] q_q;
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) q_q <= '0;
        else if (load_i) q_q <= d_i;
        else if (shift_i) q_q <= {q_q[W-2:0], ser_i};
    end
    assign ser_o = q_q[W-1];
    assign par_o = q_q[P-1:0];
endmodule

// File: rtl/trans_mdio.sv
// trans_mdio: Clause 22 MDIO frame controller (no preamble); serializes write frames,
// drives read headers, turns the bus around and captures 16 read-data bits.
module trans_mdio
    import mdio_pkg::*;
#(
    parameter int N = 31
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mdc,
    output logic               MDIO_start,
    input  logic [N:0]         T_data,
    output logic               MDIO_out,
    output logic               MDIO_oe,
    input  logic               MDIO_in,
    output logic [(N+1)/2-1:0] RD_data,
    output logic               data_RDY
);
    localparam int D = (N+1)/2;
    state_e       state_q;
    logic [5:0]   cnt_q;
    logic         oe_q, start_q, rdy_q, rd_op_q;
    logic [D-1:0] rd_q;
    logic         sr_msb;
    logic [D-2:0] sr_low;
    logic         valid, load, shift;
    assign valid = T_data[N-:2] == ST && (T_data[N-2-:2] == OP_WRITE || T_data[N-2-:2] == OP_READ);
    assign load  = state_q == IDLE && valid;
    // TA's last edge takes the first data sample, so it shifts like SEND/RECV do
    assign shift = ((state_q == SEND || state_q == RECV) && cnt_q != 6'd0) || (state_q == TA && cnt_q == 6'd0);
    mdio_shift_reg #(.W(N+1), .P(D-1)) u_sr (
        .clk     (clk),
        .rst_n_i (reset),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (T_data),
        .ser_i   (MDIO_in),
        .ser_o   (sr_msb),
        .par_o   (sr_low)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            start_q <= 1'b0;
            rdy_q   <= 1'b0;
            rd_op_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: if (valid) begin
                    state_q <= SEND;
                    oe_q    <= 1'b1;
                    start_q <= 1'b1;
                    rd_op_q <= T_data[N-2-:2] == OP_READ;
                    cnt_q   <= T_data[N-2-:2] == OP_READ ? 6'(HDR_LEN-1) : 6'(N);
                end
                SEND: if (cnt_q == 6'd0) begin
                    state_q <= rd_op_q ? TA : DONE;
                    oe_q    <= 1'b0;
                    start_q <= rd_op_q;
                    cnt_q   <= 6'(TA_LEN-1);
                end else cnt_q <= cnt_q - 6'd1;
                TA: if (cnt_q == 6'd0) begin
                    state_q <= RECV;
                    cnt_q   <= 6'(DATA_LEN-1);
                end else cnt_q <= cnt_q - 6'd1;
                RECV: if (cnt_q == 6'd0) begin
                    state_q <= DONE;
                    start_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        rd_q  <= {sr_low, MDIO_in};
                        rdy_q <= 1'b1;
                    end
                end
                DONE: if (T_data[N-:2] != ST) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mdc        = clk & reset;
    assign MDIO_oe    = oe_q;
    assign MDIO_out   = oe_q & sr_msb;
    assign MDIO_start = start_q;
    assign data_RDY   = rdy_q;
    assign RD_data    = rd_q;
endmodule

// File: tb/tb_trans_mdio.sv
// tb_trans_mdio: directed bench for trans_mdio; outputs sampled on the falling clock edge.
module tb_trans_mdio;
    logic        clk = 1'b0, reset = 1'b0, MDIO_in = 1'b0;
    logic [31:0] T_data = 32'h2FE5946D;
    logic        mdc, MDIO_start, MDIO_out, MDIO_oe, data_RDY;
    logic [15:0] RD_data;
    int          checks = 0, errors = 0;
    localparam logic [31:0] WR = 32'h5FCB28DB;
    localparam logic [31:0] RD = 32'h6FCB28DB;
    localparam logic [15:0] RB = 16'b0000_1110_1100_0110;

    trans_mdio dut (
        .clk        (clk),
        .reset      (reset),
        .mdc        (mdc),
        .MDIO_start (MDIO_start),
        .T_data     (T_data),
        .MDIO_out   (MDIO_out),
        .MDIO_oe    (MDIO_oe),
        .MDIO_in    (MDIO_in),
        .RD_data    (RD_data),
        .data_RDY   (data_RDY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_oe"}, MDIO_oe, 0);
        chk({tag, "_out"}, MDIO_out, 0);
        chk({tag, "_start"}, MDIO_start, 0);
        chk({tag, "_rdy"}, data_RDY, 0);
    endtask

    task automatic send_chk(input string tag, input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), MDIO_out, w[i]);
            chk($sformatf("%s_oe%0d", tag, i), MDIO_oe, 1);
            chk($sformatf("%s_start%0d", tag, i), MDIO_start, 1);
        end
    endtask

    task automatic rearm(input logic [31:0] w);
        T_data = 32'h0;
        @(negedge clk);
        T_data = w;
    endtask

    initial begin
        @(negedge clk);
        idle_chk("rst");
        chk("rst_rd", RD_data, 0);
        @(posedge clk); #1;
        chk("rst_mdc", mdc, 0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("inv_mdc_hi", mdc, 1);
            @(negedge clk);
            chk("inv_mdc_lo", mdc, 0);
            idle_chk("inv");
        end
        T_data = WR;
        send_chk("wr", WR, 32);
        @(negedge clk);
        idle_chk("wr_end");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_chk("wr_norepeat");
        end
        rearm(WR);
        send_chk("wr2", WR, 32);
        @(negedge clk);
        idle_chk("wr2_end");
        rearm(RD);
        send_chk("rdh", RD, 16);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ta_oe", MDIO_oe, 0);
            chk("ta_out", MDIO_out, 0);
            chk("ta_start", MDIO_start, 1);
        end
        for (int j = 15; j >= 0; j--) begin
            MDIO_in = RB[j];
            @(negedge clk);
            chk("recv_oe", MDIO_oe, 0);
            chk("recv_start", MDIO_start, 1);
            chk("recv_rdy", data_RDY, j == 0);
        end
        chk("rd_data", RD_data, 16'h0EC6);
        @(negedge clk);
        idle_chk("rd_end");
        chk("rd_hold", RD_data, 16'h0EC6);
        rearm(RD);
        send_chk("rdh2", RD, 16);
        repeat (2) @(negedge clk);
        MDIO_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_start", MDIO_start, 1);
        #2 reset = 1'b0;
        #1;
        idle_chk("abort");
        chk("abort_rd", RD_data, 0);
        @(posedge clk); #1;
        chk("abort_mdc", mdc, 0);
        @(negedge clk);
        idle_chk("abort_hold");
        chk("abort_rd_hold", RD_data, 0);
        reset = 1'b1;
        send_chk("restart", RD, 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
